// File: rtl/cam_pkg.sv
// Shared constants and FSM encoding for the camera pixel packer.
// Pixel width is fixed at 16 bits (RGB565).
package cam_pkg;
  localparam int N            = 256;
  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = N / PIX_W;
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    WAIT_FRAME,
    ACTIVE
  } cam_state_e;
endpackage

// File: rtl/cam_sync_edge.sv
// Registers camera vsync/href and derives edge strobes
// against the live inputs.
module cam_sync_edge (
  input  logic slow_clk,
  input  logic rst_slow,
  input  logic vsync,
  input  logic href,
  output logic vsync_fall,
  output logic href_q,
  output logic href_fall
);
  logic vsync_q;

  always_ff @(posedge slow_clk) begin
    if (rst_slow) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  assign vsync_fall = vsync_q & ~vsync;
  assign href_fall  = href_q & ~href;
endmodule

// File: rtl/camera_pixel_packer.sv
// Packs RGB565 camera pixels into wide words for the CDC FIFO.
// Define CAM_TEST_PATTERN_EN to replace pixels with {line, column}.
module camera_pixel_packer
  import cam_pkg::*;
#(
  parameter int N        = cam_pkg::N,
  parameter int PIX_W    = cam_pkg::PIX_W,
  parameter int H_ACTIVE = cam_pkg::H_ACTIVE,
  parameter int V_ACTIVE = cam_pkg::V_ACTIVE
) (
  input  logic         slow_clk,
  input  logic         rst_slow,
  input  logic         cam_vsync,
  input  logic         cam_href,
  input  logic         cam_byte_valid,
  input  logic [7:0]   cam_data,
  input  logic         fifo_full,
  output logic [N-1:0] data_out,
  output logic         wr_clk_en,
  output logic         frame_start,
  output logic         frame_done,
  output logic [9:0]   line_cnt,
  output logic         overflow,
  output logic         frame_err
);
  localparam int PPW    = N / PIX_W;
  localparam int SLOT_W = $clog2(PPW);

  cam_state_e state_q, state_d;

  logic             vsync_fall;
  logic             href_q;
  logic             href_fall;
  logic             phase_q;
  logic [7:0]       hi_q;
  logic [9:0]       pix_count;
  logic [N-1:0]     word_buf;
  logic [N-1:0]     word_nxt;
  logic [PIX_W-1:0] pix;
  logic [SLOT_W-1:0] slot;
  logic             emit_pend;
  logic             mid_line;

  cam_sync_edge u_edge (
    .slow_clk   (slow_clk),
    .rst_slow   (rst_slow),
    .vsync      (cam_vsync),
    .href       (cam_href),
    .vsync_fall (vsync_fall),
    .href_q     (href_q),
    .href_fall  (href_fall)
  );

  assign slot     = pix_count[SLOT_W-1:0];
  assign mid_line = href_q | phase_q | (pix_count != 10'd0);

`ifdef CAM_TEST_PATTERN_EN
  assign pix = PIX_W'({line_cnt[5:0], pix_count});
`else
  assign pix = PIX_W'({hi_q, cam_data});
`endif

  always_comb begin
    word_nxt = word_buf;
    word_nxt[slot*PIX_W +: PIX_W] = pix;
  end

  // Full is judged in the cycle the word is presented; no back-pressure.
  assign wr_clk_en = emit_pend & ~fifo_full;

  always_ff @(posedge slow_clk) begin
    if (rst_slow) state_q <= WAIT_VSYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_VSYNC: if (cam_vsync)  state_d = WAIT_FRAME;
      WAIT_FRAME: if (vsync_fall) state_d = ACTIVE;
      ACTIVE:     if (cam_vsync)  state_d = WAIT_FRAME;
      default:                    state_d = WAIT_VSYNC;
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (rst_slow) begin
      data_out    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_cnt    <= '0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      pix_count   <= '0;
      word_buf    <= '0;
      emit_pend   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      emit_pend   <= 1'b0;
      if (emit_pend && fifo_full) overflow <= 1'b1;
      unique case (state_q)
        WAIT_FRAME: begin
          if (vsync_fall) begin
            frame_start <= 1'b1;
            line_cnt    <= '0;
            phase_q     <= 1'b0;
            pix_count   <= '0;
            word_buf    <= '0;
          end
        end
        ACTIVE: begin
          if (cam_vsync) begin
            frame_done <= 1'b1;
            if (mid_line || line_cnt != 10'(V_ACTIVE)) frame_err <= 1'b1;
            phase_q   <= 1'b0;
            pix_count <= '0;
            word_buf  <= '0;
          end else if (href_fall) begin
            if (line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;
            if (pix_count != 10'(H_ACTIVE) || phase_q) frame_err <= 1'b1;
            if (slot != '0) begin
              data_out  <= word_buf;
              emit_pend <= 1'b1;
            end
            phase_q   <= 1'b0;
            pix_count <= '0;
            word_buf  <= '0;
          end else if (cam_href && cam_byte_valid) begin
            if (!phase_q) begin
              hi_q    <= cam_data;
              phase_q <= 1'b1;
            end else begin
              phase_q   <= 1'b0;
              pix_count <= pix_count + 10'd1;
              if (slot == SLOT_W'(PPW - 1)) begin
                data_out  <= word_nxt;
                emit_pend <= 1'b1;
                word_buf  <= '0;
              end else begin
                word_buf <= word_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
